// File: rtl/adder4_seq_ctrl_if.sv
// adder4_seq_ctrl_if
//   Bundles the requester handshake and the shared 4-bit full-adder
//   connection of adder4_seq_ctrl.
//   Requester side : start, sub, op_a, op_b, cin_in -> ready, busy, done,
//                    result, cout, overflow
//   Adder side     : adder_a, adder_b, adder_cin -> adder_sum, adder_carry
//   Modports: master = requester/adder side, slave = sequencer.
interface adder4_seq_ctrl_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned WIDTH = 4 * NIBBLES;

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin_in;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic [3:0]       adder_a;
   logic [3:0]       adder_b;
   logic             adder_cin;
   logic [3:0]       adder_sum;
   logic             adder_carry;

   modport master (
      output start, sub, op_a, op_b, cin_in, adder_sum, adder_carry,
      input  ready, busy, done, result, cout, overflow,
             adder_a, adder_b, adder_cin
   );

   modport slave (
      input  start, sub, op_a, op_b, cin_in, adder_sum, adder_carry,
      output ready, busy, done, result, cout, overflow,
             adder_a, adder_b, adder_cin
   );
endinterface

// File: rtl/adder4_seq_ctrl.sv
// adder4_seq_ctrl
//   Performs a 4*NIBBLES-bit add/subtract by time-multiplexing one external
//   4-bit full adder, one nibble per clock, LSB first, with the carry held
//   in a register between nibbles.
//   Ports:
//     clk   : clock, rising-edge
//     rst_n : asynchronous active-low reset
//     bus   : adder4_seq_ctrl_if.slave (handshake, operands, results and
//             the combinational connection to the shared full adder)
module adder4_seq_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   adder4_seq_ctrl_if.slave      bus
);
   localparam int unsigned WIDTH = 4 * NIBBLES;
   localparam int unsigned IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;

   logic [3:0]        slice_a, slice_b;
   logic              run, last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   // Nibble select for the current index.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDXW'(i)) begin
            slice_a = a_q[4*i +: 4];
            slice_b = b_q[4*i +: 4];
         end
      end
   end

   assign run  = (state_q == S_RUN);
   assign last = (idx_q == IDXW'(NIBBLES - 1));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               a_d     = bus.op_a;
               // Subtraction is A + ~B + 1, so B is stored pre-inverted.
               b_d     = bus.sub ? ~bus.op_b : bus.op_b;
               carry_d = bus.sub ? 1'b1 : bus.cin_in;
               idx_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDXW'(i)) begin
                  acc_d[4*i +: 4] = bus.adder_sum;
               end
            end
            carry_d = bus.adder_carry;
            idx_d   = idx_q + 1'b1;
            if (last) begin
               // acc_d already holds the top nibble from this cycle.
               result_d = acc_d;
               cout_d   = bus.adder_carry;
               // MSB carry-out XOR MSB carry-in (recovered as sum^a^b).
               ovf_d    = bus.adder_carry ^
                          (bus.adder_sum[3] ^ slice_a[3] ^ slice_b[3]);
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.adder_a   = run ? slice_a : '0;
   assign bus.adder_b   = run ? slice_b : '0;
   assign bus.adder_cin = run ? carry_q : 1'b0;

   assign bus.ready     = (state_q == S_IDLE) || (state_q == S_DONE);
   assign bus.busy      = run;
   assign bus.done      = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;
endmodule
